// File: rtl/axi_mcast_pkg.sv
// Shared AXI response encodings, B-joiner FSM states and the response severity merge.
package axi_mcast_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    RESP    = 2'b10
  } b_join_state_e;

  // Worst response wins; EXOKAY carries no meaning for a joined multicast write.
  function automatic axi_resp_e merge_resp(input axi_resp_e a, input axi_resp_e b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic FIFO: data_o valid the cycle after push (or same cycle with FALL_THROUGH).
// Pushes while full and pops while empty are ignored; no other backpressure.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  dtype            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            bypass, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fall-through bypass: a push into an empty FIFO is visible (and poppable) at once.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !(bypass && pop_i);
  assign do_pop  = pop_i && (cnt_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/axi_mcast_b_joiner.sv
// Joins the B responses of a multicast write into one slave-side B, worst response wins.
// Slave B one cycle after the last port B; port Bs not owed by the head entry are held.
module axi_mcast_b_joiner
  import axi_mcast_pkg::*;
#(
  parameter int unsigned NumMstPorts = 4,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned ExpDepth    = 4,
  parameter type         id_t        = logic [IdWidth-1:0],
  parameter type         mask_t      = logic [NumMstPorts-1:0]
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          exp_valid_i,
  output logic                          exp_ready_o,
  input  id_t                           exp_id_i,
  input  mask_t                         exp_mask_i,
  input  logic [NumMstPorts-1:0]        mst_b_valid_i,
  output logic [NumMstPorts-1:0]        mst_b_ready_o,
  input  id_t  [NumMstPorts-1:0]        mst_b_id_i,
  input  logic [NumMstPorts-1:0][1:0]   mst_b_resp_i,
  output logic                          slv_b_valid_o,
  input  logic                          slv_b_ready_i,
  output id_t                           slv_b_id_o,
  output logic [1:0]                    slv_b_resp_o,
  output logic                          merged_pop_o
);

  typedef struct packed {
    id_t   id;
    mask_t mask;
  } exp_t;

  exp_t          fifo_in, fifo_out;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  b_join_state_e state_q, state_d;
  mask_t         pend_q, pend_d;
  id_t           id_q, id_d;
  axi_resp_e     resp_q, resp_d;

  assign exp_ready_o  = ~fifo_full;
  assign fifo_push    = exp_valid_i & ~fifo_full;
  assign fifo_in.id   = exp_id_i;
  assign fifo_in.mask = exp_mask_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (ExpDepth),
    .dtype        (exp_t)
  ) i_exp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (fifo_in),
    .push_i  (fifo_push),
    .data_o  (fifo_out),
    .pop_i   (fifo_pop)
  );

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    id_d          = id_q;
    resp_d        = resp_q;
    mst_b_ready_o = '0;
    fifo_pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pend_d = fifo_out.mask;
          id_d   = fifo_out.id;
          // An entry owing no port Bs is answered as a decode error.
          if (fifo_out.mask == '0) begin
            resp_d  = RESP_DECERR;
            state_d = RESP;
          end else begin
            resp_d  = RESP_OKAY;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        for (int i = 0; i < int'(NumMstPorts); i++) begin
          if (pend_q[i] && mst_b_valid_i[i] && (mst_b_id_i[i] == id_q)) begin
            mst_b_ready_o[i] = 1'b1;
            pend_d[i]        = 1'b0;
            resp_d           = merge_resp(resp_d, axi_resp_e'(mst_b_resp_i[i]));
          end
        end
        if (pend_d == '0) state_d = RESP;
      end
      RESP: begin
        if (slv_b_ready_i) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      id_q    <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
    end
  end

  assign slv_b_valid_o = (state_q == RESP);
  assign slv_b_id_o    = id_q;
  assign slv_b_resp_o  = resp_q;
  assign merged_pop_o  = fifo_pop;

endmodule

// File: tb/tb_axi_mcast_b_joiner.sv
// Directed scenarios plus a randomized run against a queue-based response model.
module tb_axi_mcast_b_joiner;

  logic            clk_i;
  logic            rst_i;
  logic            exp_valid_i;
  logic            exp_ready_o;
  logic [3:0]      exp_id_i;
  logic [3:0]      exp_mask_i;
  logic [3:0]      mst_b_valid_i;
  logic [3:0]      mst_b_ready_o;
  logic [3:0][3:0] mst_b_id_i;
  logic [3:0][1:0] mst_b_resp_i;
  logic            slv_b_valid_o;
  logic            slv_b_ready_i;
  logic [3:0]      slv_b_id_o;
  logic [1:0]      slv_b_resp_o;
  logic            merged_pop_o;

  int total = 0;
  int bad   = 0;

  // Model state: per-port owed Bs {id,resp}, expected slave Bs {id,resp}, ports still owed per entry.
  logic [5:0] pq [4][$];
  logic [5:0] expq[$];
  logic [3:0] maskq[$];
  bit         genuine [4];
  bit         prev_hold;
  logic [5:0] prev_pl;

  axi_mcast_b_joiner dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .exp_valid_i   (exp_valid_i),
    .exp_ready_o   (exp_ready_o),
    .exp_id_i      (exp_id_i),
    .exp_mask_i    (exp_mask_i),
    .mst_b_valid_i (mst_b_valid_i),
    .mst_b_ready_o (mst_b_ready_o),
    .mst_b_id_i    (mst_b_id_i),
    .mst_b_resp_i  (mst_b_resp_i),
    .slv_b_valid_o (slv_b_valid_o),
    .slv_b_ready_i (slv_b_ready_i),
    .slv_b_id_o    (slv_b_id_o),
    .slv_b_resp_o  (slv_b_resp_o),
    .merged_pop_o  (merged_pop_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [3:0] mask);
    exp_valid_i = 1'b1;
    exp_id_i    = id;
    exp_mask_i  = mask;
  endtask

  function automatic logic [1:0] merged_of(input logic [3:0] mask, input logic [1:0] r [4]);
    int worst = 0;
    if (mask == 4'b0) return 2'b11;
    for (int i = 0; i < 4; i++)
      if (mask[i]) worst = (r[i] == 2'b11) ? 2 : (r[i] == 2'b10 && worst < 1) ? 1 : worst;
    return (worst == 2) ? 2'b11 : (worst == 1) ? 2'b10 : 2'b00;
  endfunction

  task automatic rnd_cycle(input bit allow_push);
    logic [1:0] r [4];
    logic [3:0] m;
    bit         ok;
    tick();
    exp_valid_i = allow_push && ($urandom_range(0, 2) != 0);
    exp_id_i    = 4'($urandom);
    exp_mask_i  = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      genuine[i]       = 1'b0;
      mst_b_valid_i[i] = 1'b0;
      mst_b_id_i[i]    = 4'($urandom);
      mst_b_resp_i[i]  = 2'($urandom);
      if (pq[i].size() != 0) begin
        case ($urandom_range(0, 3))
          1, 2: begin
            mst_b_valid_i[i] = 1'b1;
            {mst_b_id_i[i], mst_b_resp_i[i]} = pq[i][0];
            genuine[i] = 1'b1;
          end
          3: begin
            mst_b_valid_i[i] = 1'b1;
            mst_b_id_i[i]    = pq[i][0][5:2] ^ 4'($urandom_range(1, 15));
          end
          default: mst_b_valid_i[i] = 1'b0;
        endcase
      end else if ($urandom_range(0, 3) == 0) begin
        mst_b_valid_i[i] = 1'b1;
      end
    end
    slv_b_ready_i = ($urandom_range(0, 2) != 0);
    smp();

    chk("rnd exp_ready", exp_ready_o, expq.size() < 4);
    chk("rnd no mst ready in resp", mst_b_ready_o & {4{slv_b_valid_o}}, 0);
    for (int i = 0; i < 4; i++) begin
      if (mst_b_ready_o[i]) begin
        ok = genuine[i] && mst_b_valid_i[i] && (maskq.size() != 0);
        if (ok) ok = maskq[0][i] && (mst_b_id_i[i] == expq[0][5:2]);
        chk("rnd mst ready legal", ok, 1);
        if (ok) begin
          m    = maskq[0];
          m[i] = 1'b0;
          maskq[0] = m;
          void'(pq[i].pop_front());
        end
      end
    end

    chk("rnd merged_pop", merged_pop_o, slv_b_valid_o & slv_b_ready_i);
    if (prev_hold) begin
      chk("rnd valid held", slv_b_valid_o, 1);
      chk("rnd payload held", {slv_b_id_o, slv_b_resp_o}, prev_pl);
    end
    if (slv_b_valid_o) begin
      chk("rnd B expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        chk("rnd B payload", {slv_b_id_o, slv_b_resp_o}, expq[0]);
        chk("rnd B all ports in", maskq[0], 0);
        if (slv_b_ready_i) begin
          void'(expq.pop_front());
          void'(maskq.pop_front());
        end
      end
    end
    prev_hold = slv_b_valid_o && !slv_b_ready_i;
    prev_pl   = {slv_b_id_o, slv_b_resp_o};

    if (exp_valid_i && exp_ready_o) begin
      for (int i = 0; i < 4; i++) begin
        r[i] = 2'($urandom);
        if (exp_mask_i[i]) pq[i].push_back({exp_id_i, r[i]});
      end
      expq.push_back({exp_id_i, merged_of(exp_mask_i, r)});
      maskq.push_back(exp_mask_i);
    end
  endtask

  initial begin
    logic [3:0] got[$];
    bit         acc5;
    rst_i = 1'b1; exp_valid_i = 1'b0; exp_id_i = '0; exp_mask_i = '0;
    mst_b_valid_i = '0; mst_b_id_i = '0; mst_b_resp_i = '0; slv_b_ready_i = 1'b0;
    prev_hold = 1'b0; prev_pl = '0;

    // Reset values
    repeat (3) @(posedge clk_i);
    smp();
    chk("rst slv_valid", slv_b_valid_o, 0);
    chk("rst slv_id", slv_b_id_o, 0);
    chk("rst slv_resp", slv_b_resp_o, 0);
    chk("rst merged_pop", merged_pop_o, 0);
    chk("rst mst_ready", mst_b_ready_o, 0);
    tick(); rst_i = 1'b0;
    smp(); chk("rst exp_ready", exp_ready_o, 1);

    // Empty mask: DECERR two cycles after push, ports never accepted
    tick(); push(4'd7, 4'b0000); mst_b_valid_i = 4'hF; mst_b_id_i = {4{4'd7}};
    smp(); chk("m0 push ready", exp_ready_o, 1);
    tick(); exp_valid_i = 1'b0;
    smp(); chk("m0 valid early", slv_b_valid_o, 0); chk("m0 mst ready c1", mst_b_ready_o, 0);
    tick();
    smp(); chk("m0 valid", slv_b_valid_o, 1); chk("m0 id", slv_b_id_o, 7);
    chk("m0 resp", slv_b_resp_o, 3); chk("m0 mst ready c2", mst_b_ready_o, 0);
    chk("m0 no pop", merged_pop_o, 0);
    tick(); slv_b_ready_i = 1'b1;
    smp(); chk("m0 held", slv_b_valid_o, 1); chk("m0 pop", merged_pop_o, 1);
    tick(); slv_b_ready_i = 1'b0; mst_b_valid_i = '0;
    smp(); chk("m0 done valid", slv_b_valid_o, 0); chk("m0 done pop", merged_pop_o, 0);

    // Mask 0101 id 3, ports 0 and 2 answer two cycles apart
    tick(); push(4'd3, 4'b0101);
    smp();
    tick(); exp_valid_i = 1'b0;
    smp();
    tick(); mst_b_valid_i = 4'b0001; mst_b_id_i[0] = 4'd3; mst_b_resp_i[0] = 2'b00;
    smp(); chk("m5 accept p0", mst_b_ready_o, 4'b0001);
    tick(); mst_b_valid_i = '0;
    smp(); chk("m5 idle ready", mst_b_ready_o, 0); chk("m5 no B t+1", slv_b_valid_o, 0);
    tick(); mst_b_valid_i = 4'b0100; mst_b_id_i[2] = 4'd3; mst_b_resp_i[2] = 2'b00;
    smp(); chk("m5 accept p2", mst_b_ready_o, 4'b0100); chk("m5 no B t+2", slv_b_valid_o, 0);
    tick(); mst_b_valid_i = '0;
    smp(); chk("m5 B t+3", slv_b_valid_o, 1); chk("m5 id", slv_b_id_o, 3);
    chk("m5 resp", slv_b_resp_o, 0); chk("m5 no pop", merged_pop_o, 0);
    tick(); slv_b_ready_i = 1'b1;
    smp(); chk("m5 pop", merged_pop_o, 1);
    tick(); slv_b_ready_i = 1'b0;
    smp(); chk("m5 done", slv_b_valid_o, 0); chk("m5 pop once", merged_pop_o, 0);

    // Mask 1111, all ports in one cycle, worst response wins
    tick(); push(4'd9, 4'b1111);
    smp();
    tick(); exp_valid_i = 1'b0;
    smp();
    tick(); mst_b_valid_i = 4'hF; mst_b_id_i = {4{4'd9}}; mst_b_resp_i = {2'b11, 2'b01, 2'b10, 2'b00};
    smp(); chk("mF accept all", mst_b_ready_o, 4'hF);
    tick(); mst_b_valid_i = '0; slv_b_ready_i = 1'b1;
    smp(); chk("mF B", slv_b_valid_o, 1); chk("mF resp", slv_b_resp_o, 3);
    chk("mF id", slv_b_id_o, 9); chk("mF pop", merged_pop_o, 1);
    tick(); slv_b_ready_i = 1'b0;
    smp(); chk("mF single B", slv_b_valid_o, 0);

    // Wrong ID is held until the expected ID is presented
    tick(); push(4'd2, 4'b0010);
    smp();
    tick(); exp_valid_i = 1'b0; mst_b_valid_i = 4'b0010; mst_b_id_i[1] = 4'd5; mst_b_resp_i[1] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("id hold ready", mst_b_ready_o, 0); chk("id hold no B", slv_b_valid_o, 0);
      tick();
    end
    mst_b_id_i[1] = 4'd2;
    smp(); chk("id match ready", mst_b_ready_o, 4'b0010);
    tick(); mst_b_valid_i = '0; slv_b_ready_i = 1'b1;
    smp(); chk("id B", slv_b_valid_o, 1); chk("id B id", slv_b_id_o, 2); chk("id B resp", slv_b_resp_o, 2);
    tick(); slv_b_ready_i = 1'b0;
    smp(); chk("id done", slv_b_valid_o, 0);

    // Five pushes into a four-deep FIFO, drained in push order
    for (int k = 0; k < 5; k++) begin
      tick(); push(4'(k + 1), 4'b0000);
      smp(); chk("full push ready", exp_ready_o, k < 4);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); smp(); chk("full held", exp_ready_o, 0);
    end
    acc5 = 1'b0;
    tick(); slv_b_ready_i = 1'b1;
    for (int k = 0; k < 40 && got.size() < 5; k++) begin
      if (k != 0) tick();
      if (acc5) exp_valid_i = 1'b0;
      smp();
      if (exp_valid_i && exp_ready_o) acc5 = 1'b1;
      if (slv_b_valid_o && slv_b_ready_i) begin
        got.push_back(slv_b_id_o);
        chk("full resp", slv_b_resp_o, 3);
      end
    end
    chk("full 5th accepted", acc5, 1);
    chk("full count", got.size(), 5);
    for (int k = 0; k < got.size(); k++) chk("full order", got[k], k + 1);
    tick(); slv_b_ready_i = 1'b0; exp_valid_i = 1'b0;

    // Reset while a B is pending
    tick(); push(4'd4, 4'b0000);
    smp();
    tick(); push(4'd6, 4'b0000);
    smp();
    tick(); exp_valid_i = 1'b0;
    smp(); chk("rr in RESP", slv_b_valid_o, 1);
    tick(); slv_b_ready_i = 1'b1; #2; rst_i = 1'b1; #1;
    chk("rr valid drop", slv_b_valid_o, 0); chk("rr no pop", merged_pop_o, 0);
    chk("rr id", slv_b_id_o, 0); chk("rr resp", slv_b_resp_o, 0);
    tick(); rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      smp(); chk("rr empty no B", slv_b_valid_o, 0); chk("rr no pop after", merged_pop_o, 0);
      chk("rr exp_ready", exp_ready_o, 1);
      tick();
    end
    slv_b_ready_i = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 3000 && expq.size() != 0; c++) rnd_cycle(1'b0);
    chk("rnd drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
